// File: rtl/qspi_mem_model.sv
// qspi_mem_model: one read-only flash plus NUM_CS-1 PSRAMs on a shared quad-SPI bus, sck oversampled by clk.
// Latency: data_out/oe update in the clk after an sck edge is registered (within 2 clk of the sck fall).
// Backpressure: none; the DUT paces everything via sck, and a backdoor load wins a same-byte collision.
module qspi_mem_model #(
  parameter int                NUM_CS     = 3,
  parameter logic [NUM_CS-1:0] FLASH_MASK = 3'b001,
  parameter int                DEPTH_LOG2 = 12,
  parameter int                READ_DUMMY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      qspi_sck,
  input  logic [NUM_CS-1:0]         qspi_cs_n,
  input  logic [3:0]                qspi_data_in,
  output logic [3:0]                qspi_data_out,
  output logic [3:0]                qspi_data_oe,
  input  logic                      load_en,
  input  logic [$clog2(NUM_CS)-1:0] load_chan,
  input  logic [DEPTH_LOG2-1:0]     load_addr,
  input  logic [7:0]                load_data,
  output logic                      busy,
  output logic                      err
);
  localparam int         CHAN_W  = $clog2(NUM_CS);
  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] DUMMY_N = 4'(READ_DUMMY);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, READ, WRITE, IGNORE} state_t;

  logic [7:0] mem [NUM_CS][DEPTH];

  state_t                state_q, state_d;
  logic                  sck_q;
  logic [CHAN_W-1:0]     chan_q, chan_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            nib_q, nib_d;    // held high nibble of a command or write byte
  logic                  half_q, half_d;  // read: next fall drives low nibble; write: high nibble held
  logic                  is_wr_q, is_wr_d;
  logic [3:0]            dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  mem_we;
  logic [7:0]            rd_byte;
  logic [NUM_CS-1:0]     cs_low;
  logic                  none_sel, multi_sel, rise, fall, load_ok;
  logic [CHAN_W-1:0]     sel_idx;

  assign rise      = qspi_sck & ~sck_q;
  assign fall      = ~qspi_sck & sck_q;
  assign cs_low    = ~qspi_cs_n;
  assign none_sel  = (cs_low == '0);
  assign multi_sel = ((cs_low & (cs_low - 1'b1)) != '0);
  assign load_ok   = load_en && (int'(load_chan) < NUM_CS);
  assign rd_byte   = mem[chan_q][addr_q];

  assign qspi_data_out = dout_q;
  assign qspi_data_oe  = {4{oe_q}};
  assign busy          = busy_q;
  assign err           = err_q;

  // Encode the single active select into a channel index
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_low[i]) sel_idx = CHAN_W'(i);
    end
  end

  // Memory array: no reset so preloaded contents survive rst; backdoor is written last so it wins
  always_ff @(posedge clk) begin
    if (mem_we) mem[chan_q][addr_q] <= {nib_q, qspi_data_in};
    if (load_ok) mem[load_chan][load_addr] <= load_data;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sck_q   <= 1'b0;
      chan_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      nib_q   <= '0;
      half_q  <= 1'b0;
      is_wr_q <= 1'b0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q   <= qspi_sck;
      chan_q  <= chan_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      half_q  <= half_d;
      is_wr_q <= is_wr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Protocol sequencing: deselect and multi-select override whatever the current state is doing
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    half_d  = half_q;
    is_wr_d = is_wr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (none_sel) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
      half_d  = 1'b0;
    end else if (multi_sel) begin
      state_d = IGNORE;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          busy_d  = 1'b1;
          chan_d  = sel_idx;
          cnt_d   = '0;
          half_d  = 1'b0;
          is_wr_d = 1'b0;
          state_d = FLASH_MASK[sel_idx] ? ADDR : CMD;
        end
        CMD: if (rise) begin
          if (cnt_q == 4'd0) begin
            nib_d = qspi_data_in;
            cnt_d = 4'd1;
          end else begin
            cnt_d = '0;
            if ({nib_q, qspi_data_in} == 8'h0B) begin
              is_wr_d = 1'b0;
              state_d = ADDR;
            end else if ({nib_q, qspi_data_in} == 8'h02) begin
              is_wr_d = 1'b1;
              state_d = ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = IGNORE;
            end
          end
        end
        ADDR: if (rise) begin
          // Shifting through a DEPTH_LOG2-wide register drops the unused upper address bits
          addr_d = DEPTH_LOG2'({addr_q, qspi_data_in});
          if (cnt_q == 4'd5) begin
            cnt_d = '0;
            if (FLASH_MASK[chan_q]) state_d = MODE;
            else if (is_wr_q)       state_d = WRITE;
            else                    state_d = DUMMY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        MODE: if (rise) begin
          if (cnt_q == 4'd1) begin
            cnt_d   = '0;
            state_d = DUMMY;
          end else begin
            cnt_d = 4'd1;
          end
        end
        DUMMY: begin
          if (rise && (cnt_q < DUMMY_N)) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall && (cnt_q == DUMMY_N)) begin
            oe_d    = 1'b1;
            dout_d  = rd_byte[7:4];
            half_d  = 1'b1;
            state_d = READ;
          end
        end
        READ: if (fall) begin
          if (half_q) begin
            dout_d = rd_byte[3:0];
            addr_d = addr_q + 1'b1;
            half_d = 1'b0;
          end else begin
            dout_d = rd_byte[7:4];
            half_d = 1'b1;
          end
        end
        WRITE: if (rise) begin
          if (!half_q) begin
            nib_d  = qspi_data_in;
            half_d = 1'b1;
          end else begin
            mem_we = ~FLASH_MASK[chan_q];
            addr_d = addr_q + 1'b1;
            half_d = 1'b0;
          end
        end
        IGNORE:  oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_mem_model.sv
// tb_qspi_mem_model: directed bench for the QSPI flash/PSRAM model.
// Latency: sck phases are 3 clk long, outputs are sampled on the falling clk edge.
// Backpressure: none; the bench drives sck and selects directly.
module tb_qspi_mem_model;
  logic       clk = 1'b0;
  logic       rst;
  logic       qspi_sck;
  logic [2:0] qspi_cs_n;
  logic [3:0] qspi_data_in;
  logic [3:0] qspi_data_out;
  logic [3:0] qspi_data_oe;
  logic       load_en;
  logic [1:0] load_chan;
  logic [11:0] load_addr;
  logic [7:0] load_data;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  qspi_mem_model dut (
    .clk          (clk),
    .rst          (rst),
    .qspi_sck     (qspi_sck),
    .qspi_cs_n    (qspi_cs_n),
    .qspi_data_in (qspi_data_in),
    .qspi_data_out(qspi_data_out),
    .qspi_data_oe (qspi_data_oe),
    .load_en      (load_en),
    .load_chan    (load_chan),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sck period: present d while low, report what the DUT drives just before the rise
  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] q_oe);
    qspi_data_in = d;
    repeat (3) @(negedge clk);
    q    = qspi_data_out;
    q_oe = qspi_data_oe;
    qspi_sck = 1'b1;
    repeat (3) @(negedge clk);
    qspi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] q, qo;
    sck_cycle(b[7:4], q, qo);
    sck_cycle(b[3:0], q, qo);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) begin
      logic [3:0] q, qo;
      sck_cycle(a[4*i +: 4], q, qo);
    end
  endtask

  task automatic select(input logic [2:0] csn);
    qspi_cs_n = csn;
    repeat (3) @(negedge clk);
  endtask

  task automatic deselect();
    qspi_cs_n = 3'b111;
    repeat (3) @(negedge clk);
  endtask

  task automatic load(input logic [1:0] ch, input logic [11:0] a, input logic [7:0] d);
    load_chan = ch;
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Full read: optional command, address, mode (flash), 4 dummies, then nnib data clocks
  task automatic do_read(input logic [2:0] csn, input logic is_flash, input logic [23:0] a,
                         input int nnib, input logic [31:0] exp, input string tag, input logic desel);
    logic [3:0] q, qo;
    select(csn);
    if (!is_flash) send_byte(8'h0B);
    send_addr(a);
    if (is_flash) send_byte(8'hA0);
    for (int i = 0; i < 4; i++) sck_cycle(4'h0, q, qo);
    check({tag, "_dummy_oe"}, {4'h0, qo}, 8'h00);
    for (int i = 0; i < nnib; i++) begin
      sck_cycle(4'h0, q, qo);
      check($sformatf("%s_nib%0d", tag, i), {4'h0, q}, {4'h0, exp[4*(nnib-1-i) +: 4]});
      check($sformatf("%s_oe%0d", tag, i), {4'h0, qo}, 8'h0F);
    end
    if (desel) deselect();
  endtask

  initial begin
    logic [3:0] q, qo;
    rst = 1'b1;
    qspi_sck = 1'b0;
    qspi_cs_n = 3'b111;
    qspi_data_in = 4'h0;
    load_en = 1'b0;
    load_chan = 2'd0;
    load_addr = 12'h000;
    load_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_oe", {4'h0, qspi_data_oe}, 8'h00);
    check("rst_dout", {4'h0, qspi_data_out}, 8'h00);
    check("rst_busy", {7'h0, busy}, 8'h00);
    check("rst_err", {7'h0, err}, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Flash read of backdoor-preloaded bytes
    load(2'd0, 12'h000, 8'h11);
    load(2'd0, 12'h001, 8'h22);
    load(2'd0, 12'h002, 8'h33);
    load(2'd0, 12'h003, 8'h44);
    select(3'b110);
    check("flash_busy", {7'h0, busy}, 8'h01);
    deselect();
    do_read(3'b110, 1'b1, 24'h000000, 8, 32'h11223344, "flash", 1'b1);
    check("flash_desel_oe", {4'h0, qspi_data_oe}, 8'h00);
    check("flash_desel_busy", {7'h0, busy}, 8'h00);

    // RAM write across the top of the array, then read it back with wrap
    select(3'b101);
    send_byte(8'h02);
    send_addr(24'h000FFF);
    send_byte(8'hAB);
    send_byte(8'hCD);
    deselect();
    do_read(3'b101, 1'b0, 24'h000FFF, 4, 32'h0000ABCD, "ram_wrap", 1'b1);
    do_read(3'b101, 1'b0, 24'hABC000, 2, 32'h000000CD, "ram_hi_addr", 1'b1);

    // Partial trailing nibble is dropped on deselect
    load(2'd1, 12'h021, 8'h66);
    select(3'b101);
    send_byte(8'h02);
    send_addr(24'h000020);
    send_byte(8'h3C);
    sck_cycle(4'h9, q, qo);
    deselect();
    do_read(3'b101, 1'b0, 24'h000020, 4, 32'h00003C66, "partial", 1'b1);

    // Backdoor load in the same clk as the committing QSPI rise
    select(3'b101);
    send_byte(8'h02);
    send_addr(24'h000010);
    sck_cycle(4'h7, q, qo);
    qspi_data_in = 4'h7;
    repeat (3) @(negedge clk);
    qspi_sck  = 1'b1;
    load_chan = 2'd1;
    load_addr = 12'h010;
    load_data = 8'h5A;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
    repeat (2) @(negedge clk);
    qspi_sck  = 1'b0;
    deselect();
    do_read(3'b101, 1'b0, 24'h000010, 2, 32'h0000005A, "collide", 1'b1);
    check("no_err_yet", {7'h0, err}, 8'h00);

    // Reset in the middle of a read
    do_read(3'b110, 1'b1, 24'h000002, 2, 32'h00000033, "pre_rst", 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_oe", {4'h0, qspi_data_oe}, 8'h00);
    check("midrst_busy", {7'h0, busy}, 8'h00);
    @(negedge clk);
    qspi_cs_n = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_read(3'b110, 1'b1, 24'h000000, 4, 32'h00001122, "post_rst", 1'b1);

    // Bad command on RAM ch2: sticky error, bus never driven, memory untouched
    load(2'd2, 12'h000, 8'h9E);
    select(3'b011);
    send_byte(8'h55);
    check("badcmd_err", {7'h0, err}, 8'h01);
    send_addr(24'h000000);
    sck_cycle(4'h1, q, qo);
    check("badcmd_oe0", {4'h0, qo}, 8'h00);
    sck_cycle(4'h2, q, qo);
    check("badcmd_oe1", {4'h0, qo}, 8'h00);
    deselect();
    check("badcmd_err_sticky", {7'h0, err}, 8'h01);
    do_read(3'b011, 1'b0, 24'h000000, 2, 32'h0000009E, "badcmd_mem", 1'b1);
    check("badcmd_err_after_rd", {7'h0, err}, 8'h01);

    // Two selects low at once
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("multi_pre_err", {7'h0, err}, 8'h00);
    select(3'b100);
    check("multi_err", {7'h0, err}, 8'h01);
    sck_cycle(4'h0, q, qo);
    sck_cycle(4'hB, q, qo);
    sck_cycle(4'h0, q, qo);
    check("multi_oe", {4'h0, qo}, 8'h00);
    deselect();
    check("multi_desel_busy", {7'h0, busy}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Fixed-length directed run; this only fires if the sequence above stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
